// File: rtl/priority_encoder_rr.sv
// Registered N-to-W priority encoder with valid/ack output handshake.
// The search starts at ptr and descends with wrap; RR=1 rotates ptr after each acknowledged grant.
module priority_encoder_rr #(
    parameter int N  = 4,
    parameter int W  = 2,
    parameter int RR = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         ack,
    output logic [W-1:0] code,
    output logic [N-1:0] onehot,
    output logic         valid
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [W-1:0] TOP = W'(N - 1);

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] ptr;
    logic [W-1:0] ptr_use;
    logic [W-1:0] code_nxt;
    logic [N-1:0] onehot_nxt;
    logic [W-1:0] win;
    logic         found;

    // Next search start after grant g is acknowledged: (g-1) mod N.
    function automatic logic [W-1:0] ptr_after(input logic [W-1:0] g);
        return (g == '0) ? TOP : g - 1'b1;
    endfunction

    // Scan p, p-1, ..., 0, N-1, ..., p+1; the earliest set bit in that order wins.
    // Returns {found, index}.
    function automatic logic [W:0] arbitrate(input logic [N-1:0] r, input logic [W-1:0] p);
        logic [W:0]   res;
        logic [W-1:0] idx;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(p) >= k) ? W'(int'(p) - k) : W'(int'(p) + N - k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            code   <= '0;
            onehot <= '0;
            ptr    <= TOP;
        end else begin
            state  <= state_nxt;
            code   <= code_nxt;
            onehot <= onehot_nxt;
            ptr    <= ptr_use;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = HOLD;
            HOLD:    if (ack && !found) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The pointer is advanced first, so a back-to-back grant already uses the rotated order.
    always_comb begin
        ptr_use    = ptr;
        code_nxt   = code;
        onehot_nxt = onehot;
        if (RR != 0 && state == HOLD && ack) ptr_use = ptr_after(code);
        {found, win} = arbitrate(req, ptr_use);
        if (state == IDLE || ack) begin
            code_nxt   = found ? win : '0;
            onehot_nxt = found ? (N'(1) << win) : '0;
        end
    end

    assign valid = (state == HOLD);

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Directed bench for priority_encoder_rr: fixed priority, round-robin and an 8-input sweep,
// with expected outputs queued as each step is driven and checked after the clock edge.
module tb_priority_encoder_rr;

    typedef struct {
        string       tag;
        int          dut;
        logic        v;
        logic [3:0]  code;
        logic [15:0] oh;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req0 = '0, req1 = '0;
    logic [7:0] req2 = '0;
    logic       ack0 = 1'b0, ack1 = 1'b0, ack2 = 1'b0;
    logic [1:0] code0, code1;
    logic [2:0] code2;
    logic [3:0] oh0, oh1;
    logic [7:0] oh2;
    logic       valid0, valid1, valid2;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    priority_encoder_rr #(.N(4), .W(2), .RR(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .ack(ack0),
        .code(code0), .onehot(oh0), .valid(valid0));

    priority_encoder_rr #(.N(4), .W(2), .RR(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .ack(ack1),
        .code(code1), .onehot(oh1), .valid(valid1));

    priority_encoder_rr #(.N(8), .W(3), .RR(0)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .ack(ack2),
        .code(code2), .onehot(oh2), .valid(valid2));

    // Drive one cycle of stimulus on DUT d, queue the expectation, check after the edge.
    task automatic step(input int d, input logic rs, input logic [7:0] r, input logic a,
                        input string tag, input logic ev, input int ec);
        exp_t e;
        exp_t got;
        logic [20:0] obs;
        logic [20:0] want;
        @(negedge clk);
        rst  = rs;
        req0 = '0; req1 = '0; req2 = '0;
        ack0 = 1'b0; ack1 = 1'b0; ack2 = 1'b0;
        case (d)
            0: begin req0 = r[3:0]; ack0 = a; end
            1: begin req1 = r[3:0]; ack1 = a; end
            default: begin req2 = r; ack2 = a; end
        endcase
        e.tag  = tag;
        e.dut  = d;
        e.v    = ev;
        e.code = ev ? 4'(ec) : 4'd0;
        e.oh   = ev ? (16'd1 << ec) : 16'd0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL %s scoreboard empty obs=none exp=entry", tag);
        end else begin
            got  = sb.pop_front();
            want = {got.v, got.code, got.oh};
            case (got.dut)
                0: obs = {valid0, 2'b00, code0, 12'd0, oh0};
                1: obs = {valid1, 2'b00, code1, 12'd0, oh1};
                default: obs = {valid2, 1'b0, code2, 8'd0, oh2};
            endcase
            assert (obs === want) else begin
                fails++;
                $error("FAIL %s obs valid=%0b code=%0d onehot=%h exp valid=%0b code=%0d onehot=%h",
                       got.tag, obs[20], obs[19:16], obs[15:0], want[20], want[19:16], want[15:0]);
            end
        end
    endtask

    function automatic int top_bit(input logic [7:0] r);
        int t;
        t = -1;
        for (int i = 0; i < 8; i++) if (r[i]) t = i;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout obs=running exp=finished");
        $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
    end

    initial begin
        int hb;
        // Reset holds outputs low despite pending requests and ack
        step(0, 1'b1, 8'b1111, 1'b1, "rst_a", 1'b0, 0);
        step(0, 1'b1, 8'b1111, 1'b1, "rst_b", 1'b0, 0);
        step(0, 1'b0, 8'b1111, 1'b1, "first_grant", 1'b1, 3);

        // Fixed priority
        step(0, 1'b0, 8'b0101, 1'b1, "fp_0101_a", 1'b1, 2);
        step(0, 1'b0, 8'b0101, 1'b1, "fp_0101_b", 1'b1, 2);
        step(0, 1'b0, 8'b0101, 1'b1, "fp_0101_c", 1'b1, 2);
        step(0, 1'b0, 8'b0001, 1'b1, "fp_0001", 1'b1, 0);
        step(0, 1'b0, 8'b0000, 1'b1, "fp_release", 1'b0, 0);
        step(0, 1'b0, 8'b0000, 1'b1, "fp_idle_ack", 1'b0, 0);

        // Hold and drop
        step(0, 1'b0, 8'b0010, 1'b0, "hold_grant", 1'b1, 1);
        for (int i = 0; i < 5; i++) step(0, 1'b0, 8'b0000, 1'b0, "hold_stable", 1'b1, 1);
        step(0, 1'b0, 8'b1000, 1'b0, "hold_frozen", 1'b1, 1);
        step(0, 1'b0, 8'b0000, 1'b1, "hold_ack", 1'b0, 0);

        // Round-robin rotation
        step(1, 1'b0, 8'b1111, 1'b1, "rr_3", 1'b1, 3);
        step(1, 1'b0, 8'b1111, 1'b1, "rr_2", 1'b1, 2);
        step(1, 1'b0, 8'b1111, 1'b1, "rr_1", 1'b1, 1);
        step(1, 1'b0, 8'b1111, 1'b1, "rr_0", 1'b1, 0);
        step(1, 1'b0, 8'b1111, 1'b1, "rr_3_wrap", 1'b1, 3);
        step(1, 1'b0, 8'b1111, 1'b1, "rr_2_again", 1'b1, 2);
        step(1, 1'b0, 8'b0000, 1'b1, "rr_release", 1'b0, 0);

        // Wrap after grant 0, then reset mid-HOLD with ack (ptr 0 before reset)
        step(1, 1'b0, 8'b0001, 1'b0, "rr_grant0", 1'b1, 0);
        step(1, 1'b0, 8'b1001, 1'b1, "rr_wrap_1001", 1'b1, 3);
        step(1, 1'b0, 8'b0010, 1'b1, "rr_grant1", 1'b1, 1);
        step(1, 1'b0, 8'b0100, 1'b1, "rr_ptr0_grant2", 1'b1, 2);
        step(1, 1'b1, 8'b0011, 1'b1, "rr_mid_rst", 1'b0, 0);
        step(1, 1'b0, 8'b0011, 1'b0, "rr_after_rst", 1'b1, 1);
        step(1, 1'b0, 8'b0000, 1'b1, "rr_end", 1'b0, 0);

        // Exhaustive 8-input sweep against a highest-set-bit model
        for (int p = 0; p < 256; p++) begin
            hb = top_bit(8'(p));
            step(2, 1'b0, 8'(p), 1'b0, $sformatf("sweep_%0d", p), hb >= 0, (hb >= 0) ? hb : 0);
            step(2, 1'b0, 8'd0, 1'b1, $sformatf("sweep_ack_%0d", p), 1'b0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
